// File: rtl/vga_pkg.sv
// Shared widths and the write-buffer entry layout for the VGA tile RAM path.
package vga_pkg;

  localparam int unsigned VGA_ROW_W  = 4;
  localparam int unsigned VGA_COL_W  = 5;
  localparam int unsigned VGA_ADDR_W = 9;
  localparam int unsigned VGA_DATA_W = 32;

  typedef struct packed {
    logic [VGA_ROW_W-1:0]  row;
    logic [VGA_COL_W-1:0]  col;
    logic [VGA_DATA_W-1:0] data;
  } vga_wr_entry_t;

  localparam int unsigned VGA_WR_W = $bits(vga_wr_entry_t);

endpackage

// File: rtl/vga_wr_fifo.sv
// Synchronous first-word-fall-through FIFO; push and pop together when full is legal.
module vga_wr_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 41,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: an empty level makes every slot unreachable.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/vga_buf_arbiter.sv
// Arbitrates the single-port tile RAM between buffered bus writes and display reads,
// with read priority bounded by a write-starvation guard.
module vga_buf_arbiter
  import vga_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned STARVE_MAX = 15
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        vga_ctrl_en,
  input  logic [3:0]  vga_addr_v,
  input  logic [4:0]  vga_addr_h,
  input  logic [31:0] vga_ctrl,
  input  logic        disp_req,
  input  logic [3:0]  disp_addr_v,
  input  logic [4:0]  disp_addr_h,
  output logic        disp_valid,
  output logic [31:0] disp_rdata,
  output logic        disp_miss,
  output logic        ram_en,
  output logic        ram_we,
  output logic [8:0]  ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic [2:0]  fifo_level,
  output logic        ovf_flag,
  input  logic        ovf_clr,
  output logic [7:0]  miss_cnt
);

  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  vga_wr_entry_t   wr_entry, head;
  logic [LVL_W-1:0] level;
  logic             fifo_nempty, forced, gnt_rd, gnt_wr, push, pop, drop;

  logic [7:0]            starve_q, starve_d;
  logic                  ram_en_q, ram_en_d;
  logic                  ram_we_q, ram_we_d;
  logic [VGA_ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [VGA_DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic                  disp_valid_q, disp_valid_d;
  logic                  miss_s1_q, miss_s1_d;
  logic                  disp_miss_q, disp_miss_d;
  logic [7:0]            miss_cnt_q, miss_cnt_d;
  logic                  ovf_q, ovf_d;

  assign wr_entry = '{row: vga_addr_v, col: vga_addr_h, data: vga_ctrl};

  vga_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (VGA_WR_W)
  ) u_wr_fifo (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .push  (push),
    .pop   (pop),
    .din   (wr_entry),
    .dout  (head),
    .level (level)
  );

  // Grant priority: forced write, display read, opportunistic write, idle.
  always_comb begin
    fifo_nempty = (level != '0);
    forced      = fifo_nempty && (starve_q == 8'(STARVE_MAX));
    gnt_wr      = forced || (fifo_nempty && !disp_req);
    gnt_rd      = disp_req && !forced;
    pop         = gnt_wr;
    push        = vga_ctrl_en && ((level < LVL_W'(FIFO_DEPTH)) || pop);
    drop        = vga_ctrl_en && !push;
  end

  always_comb begin
    starve_d     = starve_q;
    ram_en_d     = gnt_rd || gnt_wr;
    ram_we_d     = gnt_wr;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    disp_valid_d = ram_en_q && !ram_we_q;
    miss_s1_d    = forced && disp_req;
    disp_miss_d  = miss_s1_q;
    miss_cnt_d   = miss_cnt_q;
    ovf_d        = ovf_q;

    if (gnt_wr || !fifo_nempty)              starve_d = '0;
    else if (starve_q < 8'(STARVE_MAX))      starve_d = starve_q + 8'd1;

    if (gnt_wr) begin
      ram_addr_d  = {head.row, head.col};
      ram_wdata_d = head.data;
    end else if (gnt_rd) begin
      ram_addr_d  = {disp_addr_v, disp_addr_h};
    end

    // Count rises together with the visible miss pulse.
    if (ovf_clr)                                  miss_cnt_d = '0;
    else if (miss_s1_q && (miss_cnt_q != 8'hFF))  miss_cnt_d = miss_cnt_q + 8'd1;

    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      starve_q     <= '0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      disp_valid_q <= 1'b0;
      miss_s1_q    <= 1'b0;
      disp_miss_q  <= 1'b0;
      miss_cnt_q   <= '0;
      ovf_q        <= 1'b0;
    end else begin
      starve_q     <= starve_d;
      ram_en_q     <= ram_en_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      disp_valid_q <= disp_valid_d;
      miss_s1_q    <= miss_s1_d;
      disp_miss_q  <= disp_miss_d;
      miss_cnt_q   <= miss_cnt_d;
      ovf_q        <= ovf_d;
    end
  end

  assign ram_en     = ram_en_q;
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign disp_valid = disp_valid_q;
  assign disp_rdata = ram_rdata;
  assign disp_miss  = disp_miss_q;
  assign miss_cnt   = miss_cnt_q;
  assign ovf_flag   = ovf_q;
  assign fifo_level = 3'(level);

endmodule

// File: doc/vga_buf_arbiter.md
Name: vga_buf_arbiter

Overview:
- Shares the single-port VGA tile/character RAM (16 rows x 32 columns x 32 bit) between two requesters: the bus-side VGA slave write stream and the display scan-out read port.
- The bus side has no back-pressure, so writes land in a small FIFO and drain into RAM in idle cycles.
- Display reads have priority, bounded by a starvation guard that forces a write through.
- The block sits between the AHB-lite VGA slave and the tile RAM / pixel pipeline.

Parameters:
- FIFO_DEPTH, 4, write-buffer entries (power of 2, ≥2).
- STARVE_MAX, 15, consecutive cycles a non-empty FIFO may be denied before a write is forced (1..255).

Ports:
- HCLK  in  1  system clock
- HRESETn  in  1  asynchronous active-low reset
- vga_ctrl_en  in  1  bus write strobe, one entry per high cycle
- vga_addr_v  in  4  bus write row
- vga_addr_h  in  5  bus write column
- vga_ctrl  in  32  bus write data
- disp_req  in  1  display read request, single-cycle, may repeat every cycle
- disp_addr_v  in  4  display read row
- disp_addr_h  in  5  display read column
- disp_valid  out  1  read data valid on disp_rdata
- disp_rdata  out  32  read data; equals ram_rdata, meaningful only when disp_valid=1
- disp_miss  out  1  pulse: request was denied, aligned with the slot its data would have had
- ram_en  out  1  RAM port enable (registered)
- ram_we  out  1  RAM write enable (registered)
- ram_addr  out  9  {row[3:0], col[4:0]} (registered)
- ram_wdata  out  32  RAM write data (registered)
- ram_rdata  in  32  RAM read data, valid 1 cycle after ram_en & ~ram_we
- fifo_level  out  3  current FIFO occupancy, 0..FIFO_DEPTH
- ovf_flag  out  1  sticky, set when a bus write is dropped
- ovf_clr  in  1  clears ovf_flag
- miss_cnt  out  8  saturating count of disp_miss pulses; cleared by ovf_clr

Behaviour:
- Reset values: all outputs 0; FIFO empty; starve_cnt=0.
- FIFO push:
  - A push occurs when vga_ctrl_en=1 and (level<FIFO_DEPTH or a pop occurs in the same cycle). The entry is {addr_v, addr_h, data}.
  - Otherwise the write is dropped and ovf_flag<=1.
  - ovf_flag set has priority over ovf_clr in the same cycle.
- Grant logic (combinational, evaluated each cycle, priority order):
  1. Forced write when starve_cnt==STARVE_MAX and level>0.
  2. Read when disp_req=1.
  3. Write when level>0.
  4. Otherwise idle.
- A write grant pops the FIFO head that same cycle.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) when level>0 and no write grant.
  - Clears on any write grant or when level==0.
- RAM port registers, loaded the cycle after the grant:
  - Read grant: ram_en=1, ram_we=0, ram_addr={disp_addr_v, disp_addr_h}.
  - Write grant: ram_en=1, ram_we=1, ram_addr/ram_wdata taken from the popped entry.
  - Idle: ram_en=0, ram_we=0; ram_addr and ram_wdata hold their values.
- Read latency: disp_req at cycle N -> ram_en at N+1 -> disp_valid=1 at N+2. Back-to-back requests are fully pipelined.
- Missed request: disp_req=1 in a forced-write cycle N gives disp_miss=1 at N+2 and disp_valid=0 at N+2. miss_cnt increments, saturating at 255.
- Writes commit to RAM in FIFO order. There is no forwarding: a display read of an address still pending in the FIFO returns the old RAM contents.
- Reset asserted mid-operation: FIFO contents are discarded, the pipeline is cleared, outputs return to 0 immediately (asynchronous).

Decomposition:
- Shared package vga_pkg:
  - VGA_ROW_W=4, VGA_COL_W=5, VGA_ADDR_W=9, VGA_DATA_W=32.
  - Write-entry struct/width constant (41 bits).
- One sub-module: vga_wr_fifo, a synchronous FIFO parameterised on depth and width.
  - Ports: push, pop, din, dout (first-word fall-through), level.
  - Simultaneous push+pop when full is legal.
- Grant logic, starvation counter, RAM registers, valid/miss pipeline and counters stay in the top level.

Test Plan:
- Idle read: disp_req with addr (3,7), ram_rdata=0xDEADBEEF -> ram_addr=0x067 at N+1; disp_valid=1 and disp_rdata=0xDEADBEEF at N+2.
- Write drain: 3 bus writes (row1 col2 0x11, row1 col3 0x22, row2 col0 0x33), disp_req=0 -> ram_we pulses in order at addr 0x022, 0x023, 0x040; fifo_level returns to 0.
- Overflow: 6 consecutive writes while disp_req=1 continuously, FIFO_DEPTH=4 -> 4 accepted, 2 dropped, ovf_flag=1; ovf_clr then clears it.
- Full with simultaneous pop: FIFO full, disp_req=0, vga_ctrl_en=1 -> push accepted, level stays 4, ovf_flag stays 0.
- Starvation: 1 write queued, disp_req held high continuously, STARVE_MAX=15 -> forced write 16 cycles after enqueue, exactly one disp_miss pulse, miss_cnt=1, reads resume the next cycle.
- Async reset mid-drain: assert HRESETn=0 with level=3 -> ram_en, disp_valid and fifo_level are 0 immediately; after release, no stale writes reach RAM.
